cv32e40p_obi2axil_bridge: RTL and testbench

//  Converts the core's OBI data interface (req/gnt/rvalid) into an AXI4-Lite master.

---
 rtl/cv32e40p_obi_axil_pkg.sv | 17 +
 rtl/cv32e40p_obi2axil_bridge.sv | 153 +++++++++++++++
 tb/tb_cv32e40p_obi2axil_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_obi_axil_pkg.sv
// Shared AXI4-Lite definitions for the OBI-to-AXI4-Lite bridge.
package cv32e40p_obi_axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (axi_resp_e'(resp) == SLVERR) || (axi_resp_e'(resp) == DECERR);
    endfunction

endpackage

// File: rtl/cv32e40p_obi2axil_bridge.sv
// OBI data-port to AXI4-Lite master bridge; in-order responses, all outstanding
// transactions of a single type (read or write).
module cv32e40p_obi2axil_bridge
    import cv32e40p_obi_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    output logic                    protocol_err_o
);

    localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MAX_OUTSTANDING);

    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    pend_we_q;
    logic                    awvalid_q, wvalid_q, arvalid_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH/8-1:0] be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    protocol_err_q;

    logic cmd_busy;
    logic gnt;
    logic live;
    logic b_ok, r_ok, unexpected;

    assign cmd_busy = awvalid_q | wvalid_q | arvalid_q;

    always_comb begin
        gnt = obi_req_i & ~cmd_busy & (cnt_q < MaxCnt) &
              ((cnt_q == '0) | (obi_we_i == pend_we_q));
    end

    // A response already registered in rsp_valid_q has consumed one outstanding slot.
    always_comb begin
        live       = cnt_q > CntWidth'(rsp_valid_q);
        b_ok       = m_bvalid & pend_we_q & live;
        r_ok       = m_rvalid & ~pend_we_q & live;
        unexpected = (m_bvalid & ~b_ok) | (m_rvalid & ~r_ok);
    end

    always_comb begin
        rsp_valid_d = b_ok | r_ok;
        rsp_rdata_d = r_ok ? m_rdata : '0;
        rsp_err_d   = 1'b0;
        if (b_ok) begin
            rsp_err_d = resp_is_err(m_bresp);
        end else if (r_ok) begin
            rsp_err_d = resp_is_err(m_rresp);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({gnt, rsp_valid_q})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q          <= '0;
            pend_we_q      <= 1'b0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (unexpected) begin
                protocol_err_q <= 1'b1;
            end
            // Grant only happens with no command in flight, so no handshake can collide.
            if (gnt) begin
                pend_we_q <= obi_we_i;
                addr_q    <= obi_addr_i;
                be_q      <= obi_be_i;
                wdata_q   <= obi_wdata_i;
                awvalid_q <= obi_we_i;
                wvalid_q  <= obi_we_i;
                arvalid_q <= ~obi_we_i;
            end else begin
                if (m_awready) awvalid_q <= 1'b0;
                if (m_wready)  wvalid_q  <= 1'b0;
                if (m_arready) arvalid_q <= 1'b0;
            end
        end
    end

    assign obi_gnt_o      = gnt;
    assign obi_rvalid_o   = rsp_valid_q;
    assign obi_rdata_o    = rsp_rdata_q;
    assign obi_err_o      = rsp_err_q;
    assign m_awvalid      = awvalid_q;
    assign m_awaddr       = addr_q;
    assign m_awprot       = AXI_PROT_DEFAULT;
    assign m_wvalid       = wvalid_q;
    assign m_wdata        = wdata_q;
    assign m_wstrb        = be_q;
    assign m_bready       = 1'b1;
    assign m_arvalid      = arvalid_q;
    assign m_araddr       = addr_q;
    assign m_arprot       = AXI_PROT_DEFAULT;
    assign m_rready       = 1'b1;
    assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_cv32e40p_obi2axil_bridge.sv
// Directed bench for the OBI-to-AXI4-Lite bridge; the bench plays the AXI slave.
module tb_cv32e40p_obi2axil_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_err;
    logic [31:0] obi_addr, obi_wdata, obi_rdata;
    logic [3:0]  obi_be;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;
    logic        protocol_err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cv32e40p_obi2axil_bridge #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .obi_req_i      (obi_req),
        .obi_gnt_o      (obi_gnt),
        .obi_addr_i     (obi_addr),
        .obi_we_i       (obi_we),
        .obi_be_i       (obi_be),
        .obi_wdata_i    (obi_wdata),
        .obi_rvalid_o   (obi_rvalid),
        .obi_rdata_o    (obi_rdata),
        .obi_err_o      (obi_err),
        .m_awvalid      (awvalid),
        .m_awready      (awready),
        .m_awaddr       (awaddr),
        .m_awprot       (awprot),
        .m_wvalid       (wvalid),
        .m_wready       (wready),
        .m_wdata        (wdata),
        .m_wstrb        (wstrb),
        .m_bvalid       (bvalid),
        .m_bready       (bready),
        .m_bresp        (bresp),
        .m_arvalid      (arvalid),
        .m_arready      (arready),
        .m_araddr       (araddr),
        .m_arprot       (arprot),
        .m_rvalid       (rvalid),
        .m_rready       (rready),
        .m_rdata        (rdata),
        .m_rresp        (rresp),
        .protocol_err_o (protocol_err)
    );

    // Inputs change just after the falling edge; outputs are checked 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        obi_req = 0; obi_we = 0; obi_addr = 0; obi_be = 0; obi_wdata = 0;
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;
        step(); step();
        #1;
        nvec++;
        if ({obi_gnt, obi_rvalid, obi_err, protocol_err} !== 4'b0000) begin
            nerr++; $display("FAIL reset_flags: got %b want 0000",
                             {obi_gnt, obi_rvalid, obi_err, protocol_err});
        end
        nvec++;
        if ({awvalid, wvalid, arvalid} !== 3'b000 || obi_rdata !== 32'h0) begin
            nerr++; $display("FAIL reset_valids: got %b rdata %h want 000 rdata 0",
                             {awvalid, wvalid, arvalid}, obi_rdata);
        end
        nvec++;
        if (bready !== 1'b1 || rready !== 1'b1) begin
            nerr++; $display("FAIL ready_tied: got b%b r%b want 1 1", bready, rready);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_read();
        step(); obi_req = 1; obi_we = 0; obi_addr = 32'h100; #1;
        nvec++;
        if (obi_gnt !== 1'b1) begin
            nerr++; $display("FAIL rd_gnt: got %b want 1", obi_gnt);
        end
        step(); obi_req = 0; arready = 1; #1;
        nvec++;
        if (arvalid !== 1'b1 || araddr !== 32'h100 || arprot !== 3'b000) begin
            nerr++; $display("FAIL rd_ar: got v%b a%h p%b want v1 a00000100 p000",
                             arvalid, araddr, arprot);
        end
        step(); arready = 0; rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b00; #1;
        nvec++;
        if (arvalid !== 1'b0 || obi_rvalid !== 1'b0) begin
            nerr++; $display("FAIL rd_c2: got arv%b rv%b want 0 0", arvalid, obi_rvalid);
        end
        step(); rvalid = 0; #1;
        nvec++;
        if (obi_rvalid !== 1'b1 || obi_rdata !== 32'hDEADBEEF || obi_err !== 1'b0) begin
            nerr++; $display("FAIL rd_rsp: got v%b d%h e%b want v1 dDEADBEEF e0",
                             obi_rvalid, obi_rdata, obi_err);
        end
        step(); #1;
        nvec++;
        if (obi_rvalid !== 1'b0) begin
            nerr++; $display("FAIL rd_single: got %b want 0", obi_rvalid);
        end
    endtask

    task automatic test_write();
        step(); obi_req = 1; obi_we = 1; obi_addr = 32'h204; obi_be = 4'b0011;
        obi_wdata = 32'h1234; #1;
        nvec++;
        if (obi_gnt !== 1'b1) begin
            nerr++; $display("FAIL wr_gnt: got %b want 1", obi_gnt);
        end
        step(); obi_req = 0; obi_addr = 32'hFFFF_FFFF; obi_wdata = 32'h0; obi_be = 0;
        wready = 1; #1;
        nvec++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h204 ||
            wdata !== 32'h1234 || wstrb !== 4'b0011 || awprot !== 3'b000) begin
            nerr++; $display("FAIL wr_cmd: got aw%b w%b a%h d%h s%b p%b want 1 1 204 1234 0011 000",
                             awvalid, wvalid, awaddr, wdata, wstrb, awprot);
        end
        for (int c = 2; c <= 4; c++) begin
            step(); wready = 0; awready = (c == 4); #1;
            nvec++;
            if (awvalid !== 1'b1 || wvalid !== 1'b0 || awaddr !== 32'h204) begin
                nerr++; $display("FAIL wr_aw_hold c%0d: got aw%b w%b a%h want 1 0 204",
                                 c, awvalid, wvalid, awaddr);
            end
        end
        step(); awready = 0; bvalid = 1; bresp = 2'b00; #1;
        nvec++;
        if (awvalid !== 1'b0 || obi_rvalid !== 1'b0) begin
            nerr++; $display("FAIL wr_aw_done: got aw%b rv%b want 0 0", awvalid, obi_rvalid);
        end
        step(); bvalid = 0; #1;
        nvec++;
        if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h0 || obi_err !== 1'b0) begin
            nerr++; $display("FAIL wr_rsp: got v%b d%h e%b want 1 0 0",
                             obi_rvalid, obi_rdata, obi_err);
        end
        step(); #1;
        nvec++;
        if (obi_rvalid !== 1'b0) begin
            nerr++; $display("FAIL wr_single: got %b want 0", obi_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_gnt;
        exp_gnt = 8'b1000_0101;  // bit k = grant expected in cycle k
        arready = 1; obi_we = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            obi_req  = 1;
            obi_addr = (c < 2) ? 32'h400 : (c < 7) ? 32'h404 : 32'h408;
            rvalid   = (c == 5) || (c == 7);
            rdata    = (c == 5) ? 32'h1111 : 32'h2222;
            #1;
            nvec++;
            if (obi_gnt !== exp_gnt[c]) begin
                nerr++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, obi_gnt, exp_gnt[c]);
            end
            if (c == 1 || c == 3) begin
                nvec++;
                if (arvalid !== 1'b1 || araddr !== ((c == 1) ? 32'h400 : 32'h404)) begin
                    nerr++; $display("FAIL b2b_ar c%0d: got v%b a%h", c, arvalid, araddr);
                end
            end
            if (c == 6) begin
                nvec++;
                if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h1111) begin
                    nerr++; $display("FAIL b2b_rsp0: got v%b d%h want 1 1111",
                                     obi_rvalid, obi_rdata);
                end
            end
        end
        step(); obi_req = 0; rvalid = 1'b1; rdata = 32'h3333; #1;
        nvec++;
        if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h2222 || arvalid !== 1'b1 ||
            araddr !== 32'h408) begin
            nerr++; $display("FAIL b2b_rsp1: got v%b d%h arv%b a%h want 1 2222 1 408",
                             obi_rvalid, obi_rdata, arvalid, araddr);
        end
        step(); rvalid = 0; #1;
        nvec++;
        if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h3333) begin
            nerr++; $display("FAIL b2b_rsp2: got v%b d%h want 1 3333", obi_rvalid, obi_rdata);
        end
        step(); #1;
        nvec++;
        if (obi_rvalid !== 1'b0) begin
            nerr++; $display("FAIL b2b_idle: got %b want 0", obi_rvalid);
        end
        arready = 0;
    endtask

    task automatic test_type_switch();
        logic [4:0] exp_gnt;
        exp_gnt = 5'b10001;
        awready = 1; wready = 1; arready = 1;
        for (int c = 0; c < 5; c++) begin
            step();
            obi_req  = 1;
            obi_we   = (c == 0);
            obi_addr = (c == 0) ? 32'h500 : 32'h504;
            bvalid   = (c == 2);
            #1;
            nvec++;
            if (obi_gnt !== exp_gnt[c]) begin
                nerr++; $display("FAIL sw_gnt c%0d: got %b want %b", c, obi_gnt, exp_gnt[c]);
            end
            if (c == 3) begin
                nvec++;
                if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h0) begin
                    nerr++; $display("FAIL sw_wr_rsp: got v%b d%h want 1 0",
                                     obi_rvalid, obi_rdata);
                end
            end
        end
        step(); obi_req = 0; #1;
        nvec++;
        if (arvalid !== 1'b1 || araddr !== 32'h504) begin
            nerr++; $display("FAIL sw_ar: got v%b a%h want 1 504", arvalid, araddr);
        end
        step(); rvalid = 1; rdata = 32'h5555; rresp = 2'b00; #1;
        step(); rvalid = 0; #1;
        nvec++;
        if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h5555) begin
            nerr++; $display("FAIL sw_rd_rsp: got v%b d%h want 1 5555", obi_rvalid, obi_rdata);
        end
        awready = 0; wready = 0; arready = 0;
    endtask

    task automatic test_slverr();
        step(); obi_req = 1; obi_we = 0; obi_addr = 32'h300; #1;
        nvec++;
        if (obi_gnt !== 1'b1) begin
            nerr++; $display("FAIL err_gnt: got %b want 1", obi_gnt);
        end
        step(); obi_req = 0; arready = 1; #1;
        step(); arready = 0; rvalid = 1; rdata = 32'hBAD0_0BAD; rresp = 2'b10; #1;
        step(); rvalid = 0; rresp = 2'b00; #1;
        nvec++;
        if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || obi_rdata !== 32'hBAD0_0BAD) begin
            nerr++; $display("FAIL err_rsp: got v%b e%b d%h want 1 1 BAD00BAD",
                             obi_rvalid, obi_err, obi_rdata);
        end
        nvec++;
        if (protocol_err !== 1'b0) begin
            nerr++; $display("FAIL err_noproto: got %b want 0", protocol_err);
        end
        step(); #1;
        nvec++;
        if (obi_err !== 1'b0 || obi_rvalid !== 1'b0) begin
            nerr++; $display("FAIL err_clear: got v%b e%b want 0 0", obi_rvalid, obi_err);
        end
    endtask

    task automatic test_unexpected_and_reset();
        step(); bvalid = 1; #1;
        step(); bvalid = 0; #1;
        nvec++;
        if (obi_rvalid !== 1'b0 || protocol_err !== 1'b1) begin
            nerr++; $display("FAIL unexp_b: got rv%b pe%b want 0 1", obi_rvalid, protocol_err);
        end
        step(); step(); #1;
        nvec++;
        if (protocol_err !== 1'b1) begin
            nerr++; $display("FAIL unexp_sticky: got %b want 1", protocol_err);
        end
        // Start a write, stall AW/W, then reset while it is in flight.
        step(); obi_req = 1; obi_we = 1; obi_addr = 32'h600; obi_wdata = 32'h66; obi_be = 4'hF;
        #1;
        step(); obi_req = 0; #1;
        nvec++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            nerr++; $display("FAIL rst_pre: got aw%b w%b want 1 1", awvalid, wvalid);
        end
        #1 rst = 1'b1;
        #1;
        nvec++;
        if ({awvalid, wvalid, arvalid, obi_rvalid, protocol_err} !== 5'b00000) begin
            nerr++; $display("FAIL rst_async: got %b want 00000",
                             {awvalid, wvalid, arvalid, obi_rvalid, protocol_err});
        end
        step(); step(); rst = 1'b0; bvalid = 1; #1;
        step(); bvalid = 0; obi_req = 1; obi_we = 0; obi_addr = 32'h700; #1;
        nvec++;
        if (obi_rvalid !== 1'b0 || protocol_err !== 1'b1) begin
            nerr++; $display("FAIL rst_late_b: got rv%b pe%b want 0 1", obi_rvalid, protocol_err);
        end
        nvec++;
        if (obi_gnt !== 1'b1) begin
            nerr++; $display("FAIL rst_cnt_clear: got %b want 1", obi_gnt);
        end
        step(); obi_req = 0; #1;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_type_switch();
        test_slverr();
        test_unexpected_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
